fc_input_loader: RTL

Front-end feeder for the fully connected layer. It accepts a serial valid/ready stream of signed activations, one word per beat, and assembles INPUT_SIZE words into a parallel register vector. It then drives the layer's start / input_valid / input_activations side and holds it stable until the layer reports done. Finally it completes the start/done release handshake and reopens the stream for the next frame.

---
 rtl/fc_input_loader.sv | 97 +++++++++
 1 files changed

// File: rtl/fc_input_loader.sv
// Serial-to-parallel activation loader for the fully connected layer.
// Collects INPUT_SIZE words, launches the layer and waits out the start/done handshake.
module fc_input_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int INPUT_SIZE  = 256,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic signed [DATA_WIDTH-1:0]          s_data,
    input  logic                                  s_last,
    output logic                                  fc_start,
    output logic                                  fc_input_valid,
    output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] fc_activations,
    input  logic                                  fc_done,
    output logic                                  frame_err,
    output logic [COUNT_WIDTH-1:0]                frame_count
);

    localparam int IDX_W = $clog2(INPUT_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                                state_q, state_d;
    logic [IDX_W-1:0]                      wr_idx_q, wr_idx_d;
    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] buf_q;
    logic                                  s_ready_q;
    logic                                  fc_start_q;
    logic                                  frame_err_q, frame_err_d;
    logic [COUNT_WIDTH-1:0]                frame_count_q;
    logic                                  accept;
    logic                                  launch;

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        frame_err_d = 1'b0;
        launch      = 1'b0;
        accept      = s_valid && s_ready_q && (state_q == FILL);
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (wr_idx_q == LAST_IDX) begin
                        // A frame with a missing last is still launched, but flagged.
                        state_d     = RUN;
                        wr_idx_d    = '0;
                        launch      = 1'b1;
                        frame_err_d = !s_last;
                    end else if (s_last) begin
                        wr_idx_d    = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            RUN:     if (fc_done)  state_d = RELEASE;
            RELEASE: if (!fc_done) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FILL;
            wr_idx_q      <= '0;
            buf_q         <= '0;
            s_ready_q     <= 1'b0;
            fc_start_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            s_ready_q   <= (state_d == FILL);
            fc_start_q  <= (state_d == RUN);
            frame_err_q <= frame_err_d;
            if (accept) buf_q[wr_idx_q] <= s_data;
            if (launch) frame_count_q <= frame_count_q + 1'b1;
        end
    end

    assign s_ready        = s_ready_q;
    assign fc_start       = fc_start_q;
    assign fc_input_valid = fc_start_q;
    assign fc_activations = buf_q;
    assign frame_err      = frame_err_q;
    assign frame_count    = frame_count_q;

endmodule
